// File: rtl/tick_window_counter.sv
// Multi-channel windowed tick counter: publishes per-channel counts and overflow flags once per window.
// Optional define TICK_WINDOW_EDGE_EN counts rising edges of tick instead of high cycles.
module tick_window_counter #(
    parameter int N  = 4,
    parameter int CH = 2,
    parameter int W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            sat_mode,
    input  logic [W-1:0]    window_len,
    input  logic [CH-1:0]   tick,
    output logic [CH*N-1:0] counts,
    output logic [CH-1:0]   of,
    output logic            valid
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] ACC_MAX = '1;

    state_t                 state;
    state_t                 state_next;
    logic [W-1:0]           len_q;
    logic [W-1:0]           win_cnt;
    logic [CH-1:0][N-1:0]   acc;
    logic [CH-1:0][N-1:0]   acc_next;
    logic [CH-1:0]          sticky;
    logic [CH-1:0]          sticky_next;
    logic [CH-1:0]          hit;
    logic                   last;
    logic                   load;
    logic                   clear;
    logic                   capture;

`ifdef TICK_WINDOW_EDGE_EN
    logic [CH-1:0] tick_q;
    logic [CH-1:0] edge_q;

    // Edge is registered, so counts lag the raw tick by one cycle against window boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
            edge_q <= '0;
        end else begin
            tick_q <= tick;
            edge_q <= tick & ~tick_q;
        end
    end

    always_comb begin
        hit = edge_q;
    end
`else
    always_comb begin
        hit = tick;
    end
`endif

    always_comb begin
        last = (win_cnt == len_q - W'(1));
    end

    always_comb begin
        acc_next    = acc;
        sticky_next = sticky;
        for (int unsigned k = 0; k < CH; k++) begin
            if (hit[k]) begin
                if (acc[k] == ACC_MAX) begin
                    sticky_next[k] = 1'b1;
                    acc_next[k]    = sat_mode ? ACC_MAX : '0;
                end else begin
                    acc_next[k] = acc[k] + N'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The last window cycle both captures and restarts, so back-to-back windows have no gap.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        clear      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (window_len != '0)) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (last) begin
                    capture = 1'b1;
                    if (window_len != '0) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                        clear      = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                clear      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q   <= '0;
            win_cnt <= '0;
            acc     <= '0;
            sticky  <= '0;
            counts  <= '0;
            of      <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                counts <= acc_next;
                of     <= sticky_next;
            end
            if (load) begin
                len_q   <= window_len;
                win_cnt <= '0;
                acc     <= '0;
                sticky  <= '0;
            end else if (clear) begin
                win_cnt <= '0;
                acc     <= '0;
                sticky  <= '0;
            end else if (state == RUN) begin
                win_cnt <= win_cnt + W'(1);
                acc     <= acc_next;
                sticky  <= sticky_next;
            end
        end
    end

endmodule

// File: tb/tb_tick_window_counter.sv
// Directed self-checking bench for tick_window_counter (N=4, CH=2, W=8, level counting).
module tb_tick_window_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sat_mode;
    logic [7:0] window_len;
    logic [1:0] tick;
    logic [7:0] counts;
    logic [1:0] of;
    logic       valid;

    int n_checks;
    int n_fail;
    int nv;
    logic lv;

    tick_window_counter #(
        .N (4),
        .CH(2),
        .W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sat_mode  (sat_mode),
        .window_len(window_len),
        .tick      (tick),
        .counts    (counts),
        .of        (of),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one window: ch0 ticks in its first n0 cycles, ch1 in its first n1.
    task automatic run_window(input int len, input int n0, input int n1, input bit first,
                              output int nvalid, output logic last_valid);
        nvalid = 0;
        if (first) begin
            enable     = 1'b1;
            window_len = len[7:0];
            tick       = '0;
            step();
            if (valid) nvalid++;
        end
        for (int i = 0; i < len; i++) begin
            tick[0] = (i < n0);
            tick[1] = (i < n1);
            step();
            if (valid) nvalid++;
        end
        tick       = '0;
        last_valid = valid;
    endtask

    task automatic stop();
        enable = 1'b0;
        tick   = '0;
        step();
        step();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        sat_mode   = 1'b0;
        window_len = '0;
        tick       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_counts", counts, 8'h00);
        check_eq("reset_of", of, 2'b00);
        check_eq("reset_valid", valid, 1'b0);
        reset = 1'b0;
        step();

        // Basic window
        run_window(10, 3, 6, 1'b1, nv, lv);
        check_eq("basic_nvalid", nv, 1);
        check_eq("basic_valid_at_end", lv, 1'b1);
        check_eq("basic_counts", counts, 8'h63);
        check_eq("basic_of", of, 2'b00);
        stop();
        check_eq("basic_valid_after_stop", valid, 1'b0);

        // Wrap overflow, then back-to-back window clears the sticky flag
        sat_mode = 1'b0;
        run_window(20, 17, 0, 1'b1, nv, lv);
        check_eq("wrap_nvalid", nv, 1);
        check_eq("wrap_counts", counts, 8'h01);
        check_eq("wrap_of", of, 2'b01);
        run_window(20, 2, 0, 1'b0, nv, lv);
        check_eq("wrap_next_nvalid", nv, 1);
        check_eq("wrap_next_counts", counts, 8'h02);
        check_eq("wrap_next_of", of, 2'b00);
        stop();

        // Saturation
        sat_mode = 1'b1;
        run_window(20, 17, 0, 1'b1, nv, lv);
        check_eq("sat_nvalid", nv, 1);
        check_eq("sat_counts", counts, 8'h0F);
        check_eq("sat_of", of, 2'b01);
        stop();
        sat_mode = 1'b0;

        // Back-to-back length-4 windows, every cycle ticking
        run_window(4, 4, 4, 1'b1, nv, lv);
        check_eq("len4_w1_nvalid", nv, 1);
        check_eq("len4_w1_valid_at_end", lv, 1'b1);
        check_eq("len4_w1_counts", counts, 8'h44);
        for (int w = 0; w < 2; w++) begin
            run_window(4, 4, 4, 1'b0, nv, lv);
            check_eq("len4_bb_nvalid", nv, 1);
            check_eq("len4_bb_valid_at_end", lv, 1'b1);
            check_eq("len4_bb_counts", counts, 8'h44);
        end
        stop();

        // Length-1 windows: valid every cycle, counts equal tick bits
        run_window(1, 1, 0, 1'b1, nv, lv);
        check_eq("len1_a_valid", lv, 1'b1);
        check_eq("len1_a_counts", counts, 8'h01);
        run_window(1, 0, 1, 1'b0, nv, lv);
        check_eq("len1_b_valid", lv, 1'b1);
        check_eq("len1_b_counts", counts, 8'h10);
        run_window(1, 1, 1, 1'b0, nv, lv);
        check_eq("len1_c_valid", lv, 1'b1);
        check_eq("len1_c_counts", counts, 8'h11);
        run_window(1, 0, 0, 1'b0, nv, lv);
        check_eq("len1_d_valid", lv, 1'b1);
        check_eq("len1_d_counts", counts, 8'h00);
        stop();

        // Abort mid-window keeps previous snapshot
        run_window(10, 3, 6, 1'b1, nv, lv);
        check_eq("abort_pre_counts", counts, 8'h63);
        stop();
        nv         = 0;
        enable     = 1'b1;
        window_len = 8'd10;
        tick       = 2'b11;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            if (valid) nv++;
        end
        enable = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (valid) nv++;
        end
        check_eq("abort_nvalid", nv, 0);
        check_eq("abort_counts_held", counts, 8'h63);
        check_eq("abort_of_held", of, 2'b00);

        // Zero-length window never produces valid
        nv         = 0;
        enable     = 1'b1;
        window_len = 8'd0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (valid) nv++;
        end
        check_eq("zero_len_nvalid", nv, 0);
        check_eq("zero_len_counts_held", counts, 8'h63);
        stop();

        // Async reset between edges, then a clean window
        run_window(20, 17, 0, 1'b1, nv, lv);
        check_eq("rst_pre_valid", lv, 1'b1);
        check_eq("rst_pre_of", of, 2'b01);
        tick = 2'b11;
        #3;
        reset = 1'b1;
        #1;
        check_eq("rst_async_counts", counts, 8'h00);
        check_eq("rst_async_of", of, 2'b00);
        check_eq("rst_async_valid", valid, 1'b0);
        #2;
        reset      = 1'b0;
        tick       = '0;
        window_len = 8'd5;
        step();
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            tick = (i < 2) ? 2'b01 : 2'b00;
            step();
            if (valid) nv++;
        end
        tick = '0;
        check_eq("rst_post_nvalid", nv, 1);
        check_eq("rst_post_counts", counts, 8'h02);
        check_eq("rst_post_of", of, 2'b00);
        stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
